// File: rtl/audio_stats_pkg.sv
// -----------------------------------------------------------------------------
// audio_stats_pkg
// Shared helpers for the audio statistics engine:
//   sum_width  - width of the per-channel window accumulator
//   zc_width   - width of the per-channel zero-crossing counter
//   sign_neg   - sign class of a sample (1 = negative, 0 = non-negative)
// -----------------------------------------------------------------------------
package audio_stats_pkg;

    // The accumulator must hold 2^log2_win full-scale samples without overflow.
    function automatic int sum_width(input int width, input int log2_win);
        return width + log2_win;
    endfunction

    // A window of 2^log2_win samples can produce up to 2^log2_win crossings
    // (the first sample may cross against the previous window's last sample).
    function automatic int zc_width(input int log2_win);
        return log2_win + 1;
    endfunction

    // Sign class used for crossing detection: zero counts as non-negative.
    function automatic logic sign_neg(input logic msb);
        return (msb == 1'b1) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/audio_stats_chan.sv
// -----------------------------------------------------------------------------
// audio_stats_chan
// Per-channel window accumulator (running max/min, sum, zero crossings) and
// the registered result outputs that are published at the end of each window.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   accept       - a sample is taken on this edge (strobe and not clr)
//   win_first    - the accepted sample is the first one of the window
//   win_last     - the accepted sample is the last one of the window
//   clr          - restart the current window; results hold
//   smpl         - signed input sample
//   max_out, min_out, avg_out, zc_out - window results
// -----------------------------------------------------------------------------
module audio_stats_chan
    import audio_stats_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_WIN = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             accept,
    input  logic                             win_first,
    input  logic                             win_last,
    input  logic                             clr,
    input  logic signed [WIDTH-1:0]          smpl,
    output logic signed [WIDTH-1:0]          max_out,
    output logic signed [WIDTH-1:0]          min_out,
    output logic signed [WIDTH-1:0]          avg_out,
    output logic [zc_width(LOG2_WIN)-1:0]    zc_out
);

    localparam int SUM_W = sum_width(WIDTH, LOG2_WIN);
    localparam int ZC_W  = zc_width(LOG2_WIN);

    logic signed [WIDTH-1:0] run_max_r;
    logic signed [WIDTH-1:0] run_min_r;
    logic signed [SUM_W-1:0] sum_r;
    logic [ZC_W-1:0]         zc_r;
    logic                    prev_neg_r;
    logic                    prev_ok_r;

    logic signed [WIDTH-1:0] max_r;
    logic signed [WIDTH-1:0] min_r;
    logic signed [WIDTH-1:0] avg_r;
    logic [ZC_W-1:0]         zc_out_r;

    logic                    smpl_neg_s;
    logic                    cross_s;
    logic signed [SUM_W-1:0] smpl_ext_s;
    logic signed [SUM_W-1:0] sum_next_s;
    logic signed [WIDTH-1:0] avg_next_s;
    logic [ZC_W-1:0]         zc_next_s;
    logic signed [WIDTH-1:0] max_next_s;
    logic signed [WIDTH-1:0] min_next_s;

    // Next-state values of the accumulators including the current sample.
    always_comb begin
        smpl_neg_s = sign_neg(smpl[WIDTH-1]);
        smpl_ext_s = {{LOG2_WIN{smpl[WIDTH-1]}}, smpl};
        sum_next_s = sum_r + smpl_ext_s;
        // Arithmetic shift floors toward -inf; the mean always fits in WIDTH.
        avg_next_s = WIDTH'(sum_next_s >>> LOG2_WIN);

        if (prev_ok_r && (smpl_neg_s != prev_neg_r)) begin
            cross_s = 1'b1;
        end else begin
            cross_s = 1'b0;
        end
        zc_next_s = zc_r + {{(ZC_W-1){1'b0}}, cross_s};

        if (win_first) begin
            max_next_s = smpl;
            min_next_s = smpl;
        end else begin
            if (smpl > run_max_r) begin
                max_next_s = smpl;
            end else begin
                max_next_s = run_max_r;
            end
            if (smpl < run_min_r) begin
                min_next_s = smpl;
            end else begin
                min_next_s = run_min_r;
            end
        end
    end

    // Accumulator update; results load only at the window end, all together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_r  <= '0;
            run_min_r  <= '0;
            sum_r      <= '0;
            zc_r       <= '0;
            prev_neg_r <= 1'b0;
            prev_ok_r  <= 1'b0;
            max_r      <= '0;
            min_r      <= '0;
            avg_r      <= '0;
            zc_out_r   <= '0;
        end else if (clr) begin
            run_max_r  <= '0;
            run_min_r  <= '0;
            sum_r      <= '0;
            zc_r       <= '0;
            prev_ok_r  <= 1'b0;
        end else if (accept) begin
            // The previous sample survives window boundaries on purpose.
            prev_neg_r <= smpl_neg_s;
            prev_ok_r  <= 1'b1;
            if (win_last) begin
                max_r     <= max_next_s;
                min_r     <= min_next_s;
                avg_r     <= avg_next_s;
                zc_out_r  <= zc_next_s;
                run_max_r <= '0;
                run_min_r <= '0;
                sum_r     <= '0;
                zc_r      <= '0;
            end else begin
                run_max_r <= max_next_s;
                run_min_r <= min_next_s;
                sum_r     <= sum_next_s;
                zc_r      <= zc_next_s;
            end
        end
    end

    assign max_out = max_r;
    assign min_out = min_r;
    assign avg_out = avg_r;
    assign zc_out  = zc_out_r;

endmodule

// File: rtl/audio_stats_monitor.sv
// -----------------------------------------------------------------------------
// audio_stats_monitor
// Per-channel audio statistics over windows of 2^LOG2_WIN sample strobes.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   smpl_vld    - sample strobe, smpl_in accepted on this edge
//   smpl_in     - packed signed samples, ch0 in the LSBs
//   clr         - restart the current window (wins over smpl_vld)
//   stats_vld   - one-cycle pulse after the result buses were updated
//   max_out, min_out, avg_out, zc_out - packed per-channel window results
//   win_cnt     - samples accepted so far in the current window
// -----------------------------------------------------------------------------
module audio_stats_monitor
    import audio_stats_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 16,
    parameter int LOG2_WIN = 10
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   smpl_vld,
    input  logic [NUM_CH*WIDTH-1:0]                smpl_in,
    input  logic                                   clr,
    output logic                                   stats_vld,
    output logic [NUM_CH*WIDTH-1:0]                max_out,
    output logic [NUM_CH*WIDTH-1:0]                min_out,
    output logic [NUM_CH*WIDTH-1:0]                avg_out,
    output logic [NUM_CH*zc_width(LOG2_WIN)-1:0]   zc_out,
    output logic [LOG2_WIN-1:0]                    win_cnt
);

    localparam int ZC_W = zc_width(LOG2_WIN);

    logic                accept_s;
    logic                win_first_s;
    logic                win_last_s;
    logic [LOG2_WIN-1:0] win_cnt_r;
    logic                stats_vld_r;

    // Shared window controls; clr discards a coincident strobe.
    always_comb begin
        accept_s    = smpl_vld && !clr;
        win_first_s = (win_cnt_r == '0);
        win_last_s  = (win_cnt_r == '1);
    end

    // Window position counter (wraps naturally) and the result-valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r   <= '0;
            stats_vld_r <= 1'b0;
        end else if (clr) begin
            win_cnt_r   <= '0;
            stats_vld_r <= 1'b0;
        end else begin
            if (accept_s) begin
                win_cnt_r <= win_cnt_r + LOG2_WIN'(1'b1);
            end
            stats_vld_r <= accept_s && win_last_s;
        end
    end

    assign win_cnt   = win_cnt_r;
    assign stats_vld = stats_vld_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        audio_stats_chan #(
            .WIDTH    (WIDTH),
            .LOG2_WIN (LOG2_WIN)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .accept    (accept_s),
            .win_first (win_first_s),
            .win_last  (win_last_s),
            .clr       (clr),
            .smpl      (smpl_in[g*WIDTH +: WIDTH]),
            .max_out   (max_out[g*WIDTH +: WIDTH]),
            .min_out   (min_out[g*WIDTH +: WIDTH]),
            .avg_out   (avg_out[g*WIDTH +: WIDTH]),
            .zc_out    (zc_out[g*ZC_W +: ZC_W])
        );
    end

endmodule

// File: tb/tb_audio_stats_monitor.sv
// -----------------------------------------------------------------------------
// tb_audio_stats_monitor
// Self-checking bench: NUM_CH=2, WIDTH=16, LOG2_WIN=4 (16-sample windows).
// The reference model keeps the raw samples of the current window and derives
// max/min/floor-mean/crossings from them when the window completes.
// -----------------------------------------------------------------------------
module tb_audio_stats_monitor;

    localparam int NUM_CH   = 2;
    localparam int WIDTH    = 16;
    localparam int LOG2_WIN = 4;
    localparam int WIN      = 16;
    localparam int ZW       = LOG2_WIN + 1;
    localparam int BUS_W    = 3*NUM_CH*WIDTH + NUM_CH*ZW;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     smpl_vld;
    logic [NUM_CH*WIDTH-1:0]  smpl_in;
    logic                     clr;
    logic                     stats_vld;
    logic [NUM_CH*WIDTH-1:0]  max_out;
    logic [NUM_CH*WIDTH-1:0]  min_out;
    logic [NUM_CH*WIDTH-1:0]  avg_out;
    logic [NUM_CH*ZW-1:0]     zc_out;
    logic [LOG2_WIN-1:0]      win_cnt;

    audio_stats_monitor #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .smpl_vld  (smpl_vld),
        .smpl_in   (smpl_in),
        .clr       (clr),
        .stats_vld (stats_vld),
        .max_out   (max_out),
        .min_out   (min_out),
        .avg_out   (avg_out),
        .zc_out    (zc_out),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vld_cycles = 0;

    always @(negedge clk) begin
        if (stats_vld === 1'b1) vld_cycles++;
    end

    // ---------------- reference model ----------------
    int win_q[NUM_CH][$];
    int last_smp[NUM_CH];
    bit last_ok = 1'b0;
    int start_smp[NUM_CH];
    bit start_ok = 1'b0;
    int exp_max[NUM_CH];
    int exp_min[NUM_CH];
    int exp_avg[NUM_CH];
    int exp_zc[NUM_CH];
    int windows = 0;

    task automatic model_clear(input bit zero_outputs);
        for (int c = 0; c < NUM_CH; c++) begin
            win_q[c].delete();
            if (zero_outputs) begin
                exp_max[c] = 0; exp_min[c] = 0; exp_avg[c] = 0; exp_zc[c] = 0;
            end
        end
        last_ok  = 1'b0;
        start_ok = 1'b0;
    endtask

    task automatic model_accept(input int s0, input int s1);
        int s[NUM_CH];
        int mx, mn, sum, zc, avg;
        s[0] = s0; s[1] = s1;
        if (win_q[0].size() == 0) begin
            start_ok = last_ok;
            for (int c = 0; c < NUM_CH; c++) start_smp[c] = last_smp[c];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            win_q[c].push_back(s[c]);
            last_smp[c] = s[c];
        end
        last_ok = 1'b1;
        if (win_q[0].size() == WIN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mx = win_q[c][0]; mn = win_q[c][0]; sum = 0; zc = 0;
                for (int i = 0; i < WIN; i++) begin
                    if (win_q[c][i] > mx) mx = win_q[c][i];
                    if (win_q[c][i] < mn) mn = win_q[c][i];
                    sum += win_q[c][i];
                    if (i == 0) begin
                        if (start_ok && ((win_q[c][0] < 0) != (start_smp[c] < 0))) zc++;
                    end else if ((win_q[c][i] < 0) != (win_q[c][i-1] < 0)) begin
                        zc++;
                    end
                end
                avg = sum / WIN;
                if (sum < 0 && (sum % WIN) != 0) avg = avg - 1;
                exp_max[c] = mx; exp_min[c] = mn; exp_avg[c] = avg; exp_zc[c] = zc;
                win_q[c].delete();
            end
            windows++;
        end
    endtask

    function automatic logic [BUS_W-1:0] exp_bus();
        logic [NUM_CH*WIDTH-1:0] a, b, v;
        logic [NUM_CH*ZW-1:0]    z;
        int t;
        for (int c = 0; c < NUM_CH; c++) begin
            t = exp_max[c]; a[c*WIDTH +: WIDTH] = t[WIDTH-1:0];
            t = exp_min[c]; b[c*WIDTH +: WIDTH] = t[WIDTH-1:0];
            t = exp_avg[c]; v[c*WIDTH +: WIDTH] = t[WIDTH-1:0];
            t = exp_zc[c];  z[c*ZW +: ZW]       = t[ZW-1:0];
        end
        return {a, b, v, z};
    endfunction

    function automatic int rnd_smp();
        logic signed [WIDTH-1:0] r;
        r = WIDTH'($urandom);
        return int'(r);
    endfunction

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at a negedge after the accepting edge.
    task automatic send(input int s0, input int s1, input bit with_clr, input int gap);
        smpl_in[WIDTH-1:0]       = s0[WIDTH-1:0];
        smpl_in[2*WIDTH-1:WIDTH] = s1[WIDTH-1:0];
        smpl_vld = 1'b1;
        clr      = with_clr;
        @(negedge clk);
        smpl_vld = 1'b0;
        clr      = 1'b0;
        if (with_clr) model_clear(1'b0);
        else          model_accept(s0, s1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear(1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; smpl_vld = 1'b0; clr = 1'b0; smpl_in = '0;
        model_clear(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if ({max_out, min_out, avg_out, zc_out} !== exp_bus()) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
        checks++;
        if ({stats_vld, win_cnt} !== 5'd0) begin
            errors++; $display("FAIL reset_ctrl: got vld=%b cnt=%0d want 0", stats_vld, win_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_constant();
        int v0;
        v0 = vld_cycles;
        for (int i = 0; i < WIN; i++) send(100, -7, 1'b0, 0);
        checks++;
        if (stats_vld !== 1'b1) begin
            errors++; $display("FAIL const_vld: got %b want 1", stats_vld);
        end
        checks++;
        if ({max_out, min_out, avg_out, zc_out} !== exp_bus()) begin
            errors++; $display("FAIL const_bus: got %h want %h", {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
        checks++;
        if ({max_out[15:0], min_out[31:16], avg_out[15:0], avg_out[31:16], zc_out} !== {16'sd100, -16'sd7, 16'sd100, -16'sd7, 10'd0}) begin
            errors++; $display("FAIL const_values: got max0=%0d min1=%0d avg0=%0d avg1=%0d zc=%h", $signed(max_out[15:0]),
                $signed(min_out[31:16]), $signed(avg_out[15:0]), $signed(avg_out[31:16]), zc_out);
        end
        @(negedge clk);
        checks++;
        if (stats_vld !== 1'b0) begin
            errors++; $display("FAIL const_pulse_len: got %b want 0", stats_vld);
        end
        #1;
        checks++;
        if (vld_cycles - v0 !== 1) begin
            errors++; $display("FAIL const_pulse_count: got %0d want 1", vld_cycles - v0);
        end
    endtask

    task automatic test_alternating();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WIN; i++) send((i % 2 == 0) ? 1000 : -1000, rnd_smp(), 1'b0, 0);
            checks++;
            if ({stats_vld, max_out, min_out, avg_out, zc_out} !== {1'b1, exp_bus()}) begin
                errors++; $display("FAIL alt_bus_w%0d: got %b %h want 1 %h", w, stats_vld, {max_out, min_out, avg_out, zc_out}, exp_bus());
            end
            checks++;
            if (zc_out[ZW-1:0] !== ((w == 0) ? 5'd15 : 5'd16)) begin
                errors++; $display("FAIL alt_zc_w%0d: got %0d want %0d", w, zc_out[ZW-1:0], (w == 0) ? 15 : 16);
            end
        end
        checks++;
        if ({max_out[15:0], min_out[15:0], avg_out[15:0]} !== {16'sd1000, -16'sd1000, 16'sd0}) begin
            errors++; $display("FAIL alt_values: got max=%0d min=%0d avg=%0d", $signed(max_out[15:0]),
                $signed(min_out[15:0]), $signed(avg_out[15:0]));
        end
    endtask

    task automatic test_floor();
        for (int i = 0; i < WIN; i++) send((i % 2 == 0) ? -3 : -4, rnd_smp(), 1'b0, 0);
        checks++;
        if ({max_out, min_out, avg_out, zc_out} !== exp_bus()) begin
            errors++; $display("FAIL floor_bus: got %h want %h", {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
        checks++;
        if (avg_out[15:0] !== 16'hFFFC) begin
            errors++; $display("FAIL floor_avg: got %0d want -4", $signed(avg_out[15:0]));
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < WIN; i++) send((i < 8) ? -32768 : 32767, rnd_smp(), 1'b0, 1);
        checks++;
        if ({max_out, min_out, avg_out, zc_out} !== exp_bus()) begin
            errors++; $display("FAIL full_bus: got %h want %h", {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
        checks++;
        if ({max_out[15:0], min_out[15:0], avg_out[15:0], zc_out[4:0]} !== {16'h7FFF, 16'h8000, 16'hFFFF, 5'd1}) begin
            errors++; $display("FAIL full_values: got max=%0d min=%0d avg=%0d zc=%0d", $signed(max_out[15:0]),
                $signed(min_out[15:0]), $signed(avg_out[15:0]), zc_out[4:0]);
        end
    endtask

    task automatic test_clr();
        int v0;
        v0 = vld_cycles;
        for (int i = 0; i < 9; i++) send(rnd_smp(), rnd_smp(), 1'b0, 1);
        checks++;
        if (int'(win_cnt) !== win_q[0].size()) begin
            errors++; $display("FAIL clr_midcount: got %0d want %0d", win_cnt, win_q[0].size());
        end
        send(rnd_smp(), rnd_smp(), 1'b1, 0);
        checks++;
        if ({stats_vld, win_cnt, max_out, min_out, avg_out, zc_out} !== {1'b0, 4'd0, exp_bus()}) begin
            errors++; $display("FAIL clr_hold: got %b %0d %h want 0 0 %h", stats_vld, win_cnt,
                {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
        for (int i = 0; i < WIN - 1; i++) send(rnd_smp(), rnd_smp(), 1'b0, 0);
        #1;
        checks++;
        if ({vld_cycles - v0, max_out, min_out, avg_out, zc_out} !== {32'd0, exp_bus()}) begin
            errors++; $display("FAIL clr_early: got pulses=%0d bus=%h want 0 %h", vld_cycles - v0,
                {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
        send(rnd_smp(), rnd_smp(), 1'b0, 0);
        checks++;
        if ({stats_vld, max_out, min_out, avg_out, zc_out} !== {1'b1, exp_bus()}) begin
            errors++; $display("FAIL clr_window: got %b %h want 1 %h", stats_vld, {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
    endtask

    task automatic test_async_reset();
        int v0;
        for (int i = 0; i < 6; i++) send(rnd_smp(), rnd_smp(), 1'b0, 0);
        v0 = vld_cycles;
        rst_n = 1'b0;
        model_clear(1'b1);
        #1;
        checks++;
        if ({stats_vld, win_cnt, max_out, min_out, avg_out, zc_out} !== {1'b0, 4'd0, exp_bus()}) begin
            errors++; $display("FAIL areset_zero: got %b %0d %h want all 0", stats_vld, win_cnt, {max_out, min_out, avg_out, zc_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIN; i++) send(rnd_smp(), rnd_smp(), 1'b0, $urandom_range(0, 2));
        #1;
        checks++;
        if ({vld_cycles - v0, max_out, min_out, avg_out, zc_out} !== {32'd1, exp_bus()}) begin
            errors++; $display("FAIL areset_window: got pulses=%0d bus=%h want 1 %h", vld_cycles - v0,
                {max_out, min_out, avg_out, zc_out}, exp_bus());
        end
    endtask

    task automatic test_spacing();
        int d0[WIN];
        int d1[WIN];
        int v0;
        for (int i = 0; i < WIN; i++) begin d0[i] = rnd_smp(); d1[i] = rnd_smp(); end
        for (int run = 0; run < 2; run++) begin
            do_clr();
            v0 = vld_cycles;
            for (int i = 0; i < WIN; i++) send(d0[i], d1[i], 1'b0, (run == 0 || i == WIN - 1) ? 0 : 49);
            checks++;
            if ({stats_vld, max_out, min_out, avg_out, zc_out} !== {1'b1, exp_bus()}) begin
                errors++; $display("FAIL spacing_bus_r%0d: got %b %h want 1 %h", run, stats_vld,
                    {max_out, min_out, avg_out, zc_out}, exp_bus());
            end
            repeat (3) @(negedge clk);
            #1;
            checks++;
            if (vld_cycles - v0 !== 1) begin
                errors++; $display("FAIL spacing_pulse_r%0d: got %0d want 1", run, vld_cycles - v0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        int w0;
        v0 = vld_cycles;
        w0 = windows;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < WIN; i++) send(rnd_smp(), rnd_smp(), 1'b0, (i == WIN - 1) ? 0 : $urandom_range(0, 2));
            checks++;
            if ({stats_vld, max_out, min_out, avg_out, zc_out} !== {1'b1, exp_bus()}) begin
                errors++; $display("FAIL b2b_bus_w%0d: got %b %h want 1 %h", w, stats_vld,
                    {max_out, min_out, avg_out, zc_out}, exp_bus());
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (vld_cycles - v0 !== windows - w0) begin
            errors++; $display("FAIL b2b_pulses: got %0d want %0d", vld_cycles - v0, windows - w0);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_alternating();
        test_floor();
        test_full_scale();
        test_clr();
        test_async_reset();
        test_spacing();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_stats_monitor.md
# audio_stats_monitor

Synthesizable per-channel audio statistics engine for the equalizer datapath. It accepts one signed sample per channel on each sample strobe, normally derived from the LRCLK edge. Over a window of 2^LOG2_WIN strobes it accumulates maximum, minimum, mean and zero-crossing count for every channel, then publishes all results together with a one-cycle valid pulse. It replaces simulation-only level and crossing checks with hardware usable on-chip, for example for LED level metering.

## Interface
- NUM_CH, 2, number of audio channels (ch0 = left, ch1 = right by convention).
- WIDTH, 16, sample width, signed two's complement.
- LOG2_WIN, 10, window length = 2^LOG2_WIN samples; legal range 1..16.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- smpl_vld  in  1  one-cycle strobe; the samples on smpl_in are accepted on this edge.
- smpl_in  in  NUM_CH*WIDTH  packed samples, ch0 in the LSBs.
- clr  in  1  synchronous restart of the current window.
- stats_vld  out  1  one-cycle pulse; the result buses were updated on the previous edge.
- max_out  out  NUM_CH*WIDTH  per-channel window maximum (signed).
- min_out  out  NUM_CH*WIDTH  per-channel window minimum (signed).
- avg_out  out  NUM_CH*WIDTH  per-channel window mean (signed).
- zc_out  out  NUM_CH*(LOG2_WIN+1)  per-channel zero-crossing count.
- win_cnt  out  LOG2_WIN  samples accepted so far in the current window.

## Operation
- Reset: all outputs are 0, all accumulators are 0, and the prev-sample-valid flag is cleared.
- Each channel keeps these registers: run_max, run_min, sum (WIDTH+LOG2_WIN bits, signed), zc count, prev sample, and prev_ok.
- The first sample of a window (win_cnt==0) loads run_max and run_min directly. Later samples update them with signed compare.
- sum accumulates sign-extended samples and cannot overflow: the width covers 2^LOG2_WIN × full scale.
- Sign class: negative means the MSB is 1; non-negative means the MSB is 0.
  - A crossing is counted when prev_ok=1 and the sign class differs from the prev sample.
  - prev and prev_ok persist across window boundaries. The first sample of a window can therefore count a crossing against the last sample of the previous window.
  - The maximum count is 2^LOG2_WIN, which is why the counter is LOG2_WIN+1 bits.
- End of window: the accepted sample has win_cnt == 2^LOG2_WIN−1.
  - On that edge, the result buses load the final values including that sample.
  - avg = (sum + sample) >>> LOG2_WIN, an arithmetic shift that floors toward −inf.
  - The accumulators and zc clear, and win_cnt wraps to 0.
  - stats_vld = 1 for the next cycle only.
- The result buses hold their values until the next window end; they are never partially updated.
- clr: win_cnt, sum, zc, run_max/min and prev_ok clear; the outputs hold their values.
  - If clr and smpl_vld are high in the same cycle, clr wins and the sample is discarded.
- A window is defined by the number of accepted strobes, not by elapsed time. Arbitrarily long gaps between strobes are legal.
- smpl_vld asserted on consecutive cycles: every cycle is accepted and throughput is 1 sample/cycle.
- Asynchronous reset mid-window: the partial window is lost and no stats_vld is issued for it.

## Timing
- There is no backpressure: the block always accepts a strobe.
- Latency: the last sample is accepted on edge E, the results are visible after E, and stats_vld is high from E to E+1.
- Back-to-back windows with LOG2_WIN=1 and continuous strobes produce stats_vld every 2 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package audio_stats_pkg provides:
  - the function for the sum width (WIDTH+LOG2_WIN);
  - the function for the zc width (LOG2_WIN+1);
  - a sign-class helper.
- Sub-module audio_stats_chan implements the per-channel accumulator and output registers. It takes win_first, win_last, accept and clr as shared controls.
- The top level holds the shared win_cnt, the stats_vld flop, and a generate loop over NUM_CH.

## Test plan
- NUM_CH=2, LOG2_WIN=4, ch0 constant +100, ch1 constant −7 for 16 strobes -> one stats_vld after strobe 16; ch0 max=min=avg=100, zc=0; ch1 max=min=avg=−7, zc=0.
- ch0 alternating +1000/−1000 starting positive, over 32 strobes after reset -> window 1: max=1000, min=−1000, avg=0, zc=15; window 2: zc=16.
- ch0 samples −3,−4 repeated over 16 strobes -> avg=−4 (sum −56, >>>4 floors to −4).
- Full scale: ch0 = −32768 ×8 then 32767 ×8 -> max=32767, min=−32768, avg=−1 (sum −8 >>>4), zc=1, with no overflow.
- clr asserted together with strobe 10 -> the sample is discarded, stats_vld appears only after 16 further strobes, and the outputs keep their previous values until then. Separately, rst_n pulsed low at strobe 7 -> all outputs go to 0 immediately, and the next stats_vld appears after 16 new strobes.
- Strobes on 16 consecutive cycles versus strobes spaced 50 cycles apart with identical data -> identical results, with stats_vld exactly one cycle long in both cases.
